// File: rtl/tdc_phase_detector_if.sv
// tdc_phase_detector_if: phase error stream from the detector to the PLL loop filter
//   phase_valid  one-cycle pulse, new phase_err available
//   phase_err    signed error, held between pulses
//   timeout      pulses with phase_valid when the measurement timed out
//   locked       lock indicator (0 when lock detection is not built)
interface tdc_phase_detector_if #(
    parameter int ERR_W = 18
) ();
    logic             phase_valid;
    logic [ERR_W-1:0] phase_err;
    logic             timeout;
    logic             locked;

    modport master (output phase_valid, phase_err, timeout, locked);
    modport slave  (input  phase_valid, phase_err, timeout, locked);
endinterface

// File: rtl/tdc_phase_detector.sv
// tdc_phase_detector: counter-based phase/frequency detector feeding the PLL loop filter
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   ena     detector enable; low aborts any measurement and clears lock
//   ref_in  reference clock, asynchronous to clk
//   fb_in   divided DCO feedback, asynchronous to clk
//   pd      phase stream (phase_valid, phase_err, timeout, locked)
// Positive phase_err: fb lags ref. Lock detection is built only with PD_LOCK_DET_EN defined.
module tdc_phase_detector #(
    parameter int ERR_W       = 18,
    parameter int GAIN_SH     = 4,
    parameter int TIMEOUT_CYC = 4096,
    parameter int LOCK_TOL    = 32,
    parameter int LOCK_CNT    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 ref_in,
    input  logic                 fb_in,
    tdc_phase_detector_if.master pd
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam int PW    = CNT_W + GAIN_SH;
    localparam int MW    = (PW > ERR_W) ? PW : ERR_W;
    localparam logic [ERR_W-1:0] ERR_MAX = {1'b0, {(ERR_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT_CYC);

    if (ERR_W < 2 || TIMEOUT_CYC < 1 || LOCK_TOL < 0 || LOCK_CNT < 1) begin : g_param_chk
        $error("tdc_phase_detector: invalid parameters");
    end

    typedef enum logic [1:0] {IDLE, REF_LEAD, FB_LEAD} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       ref_s, fb_s;
    logic             ref_rise, fb_rise;
    logic [MW-1:0]    prod;
    logic [ERR_W-1:0] mag, ee, err_q;
    logic             ev, et, pv_q, to_q, lock_q;

    // [0],[1] synchroniser, [2] edge-detect delay; identical on both inputs so latency cancels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_s <= '0;
            fb_s  <= '0;
        end else begin
            ref_s <= {ref_s[1:0], ref_in};
            fb_s  <= {fb_s[1:0], fb_in};
        end
    end

    assign ref_rise = ref_s[1] & ~ref_s[2];
    assign fb_rise  = fb_s[1] & ~fb_s[2];

    // Scaling is done wide enough that it can never overflow before saturation
    assign prod = MW'(cnt) << GAIN_SH;
    assign mag  = (prod > MW'(ERR_MAX)) ? ERR_MAX : prod[ERR_W-1:0];

    // Emit decode for the current cycle; registered below
    always_comb begin
        ev = 1'b0;
        ee = '0;
        et = 1'b0;
        if (ena) begin
            case (state)
                IDLE: ev = ref_rise & fb_rise;
                REF_LEAD: begin
                    ev = fb_rise | ref_rise | (cnt == CNT_TO);
                    ee = fb_rise ? mag : ERR_MAX;
                    et = ~fb_rise & ~ref_rise & (cnt == CNT_TO);
                end
                FB_LEAD: begin
                    ev = ref_rise | fb_rise | (cnt == CNT_TO);
                    ee = ref_rise ? -mag : -ERR_MAX;
                    et = ~ref_rise & ~fb_rise & (cnt == CNT_TO);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            pv_q  <= 1'b0;
            to_q  <= 1'b0;
            err_q <= '0;
        end else begin
            pv_q <= ev;
            to_q <= et;
            if (ev)
                err_q <= ee;
            if (!ena) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= (ref_rise & ~fb_rise) ? REF_LEAD : (fb_rise & ~ref_rise) ? FB_LEAD : IDLE;
                        cnt   <= CNT_W'(ref_rise ^ fb_rise);
                    end
                    // A new leading edge (alone or with the closing edge) restarts the count
                    REF_LEAD: begin
                        if (ref_rise)
                            cnt <= CNT_W'(1);
                        else if (fb_rise || cnt == CNT_TO) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else
                            cnt <= cnt + 1'b1;
                    end
                    FB_LEAD: begin
                        if (fb_rise)
                            cnt <= CNT_W'(1);
                        else if (ref_rise || cnt == CNT_TO) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else
                            cnt <= cnt + 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

`ifdef PD_LOCK_DET_EN
    localparam int LW = $clog2(LOCK_CNT + 1);
    localparam logic [LW-1:0] LCNT = LW'(LOCK_CNT);

    logic [LW-1:0]    lock_cnt;
    logic [ERR_W-1:0] abs_e;
    logic             in_win;

    assign abs_e  = ee[ERR_W-1] ? -ee : ee;
    assign in_win = (abs_e <= ERR_W'(LOCK_TOL)) & ~et;

    // Evaluated on the emit decode so locked rises together with the qualifying pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt <= '0;
            lock_q   <= 1'b0;
        end else if (!ena) begin
            lock_cnt <= '0;
            lock_q   <= 1'b0;
        end else if (ev) begin
            if (in_win) begin
                lock_cnt <= (lock_cnt == LCNT) ? lock_cnt : lock_cnt + 1'b1;
                lock_q   <= lock_cnt >= LCNT - 1'b1;
            end else begin
                lock_cnt <= '0;
                lock_q   <= 1'b0;
            end
        end
    end
`else
    assign lock_q = 1'b0;
`endif

    assign pd.phase_valid = pv_q;
    assign pd.phase_err   = err_q;
    assign pd.timeout     = to_q;
    assign pd.locked      = lock_q;
endmodule
